// File: rtl/btpipe_pkg.sv
// btpipe_pkg: shared definitions for the block output pipe scheduler.
//   sched_state_t   : scheduler state encoding (IDLE, GRANT, XFER)
//   DEF_BLOCK_WORDS : default 32-bit words per block
//   DEF_LEVEL_W     : default width of a requester fill-level input
package btpipe_pkg;

   localparam int unsigned DEF_BLOCK_WORDS = 256;
   localparam int unsigned DEF_LEVEL_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector.
//   eligible [NREQ] : requesters able to supply a full block
//   ptr      [3]    : index of the most recently granted requester
//   idx      [3]    : first eligible index after ptr, wrapping NREQ-1 -> 0
//   valid    [1]    : at least one requester is eligible
module rr_pick #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [2:0]      ptr,
   output logic [2:0]      idx,
   output logic            valid
);

   // Two ascending passes: indices above ptr first, then the wrapped range
   // 0..ptr, which puts ptr itself last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!valid && (i > 32'(ptr)) && eligible[i]) begin
            valid = 1'b1;
            idx   = 3'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!valid && (i <= 32'(ptr)) && eligible[i]) begin
            valid = 1'b1;
            idx   = 3'(i);
         end
      end
   end

endmodule

// File: rtl/btpipe_out_sched.sv
// btpipe_out_sched: grants whole blocks of a block output pipe endpoint to
// one of NREQ first-word-fall-through requesters, in round-robin order.
//   okClk, rst         : clock, asynchronous active-high reset
//   ep_read            : word read strobe from the endpoint
//   ep_blockstrobe     : block start strobe from the endpoint
//   ep_datain  [32]    : head word of the granted requester during XFER, else 0
//   ep_ready           : a full block is available (registered)
//   req_level  [NREQ*LEVEL_W] : words available per requester
//   req_data   [NREQ*32]      : head word per requester
//   req_rd     [NREQ]  : one-hot pop to the granted requester
//   grant_id   [3]     : granted requester index
//   busy               : high in GRANT and XFER
//   err                : sticky protocol error, cleared only by rst
//   blk_count  [NREQ*16] : completed blocks per requester, saturating
//                          (only with BTPIPE_OUT_SCHED_STATS_EN defined)
module btpipe_out_sched
   import btpipe_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
   parameter int unsigned LEVEL_W     = DEF_LEVEL_W
) (
   input  logic                      okClk,
   input  logic                      rst,
   input  logic                      ep_read,
   input  logic                      ep_blockstrobe,
   output logic [31:0]               ep_datain,
   output logic                      ep_ready,
   input  logic [NREQ*LEVEL_W-1:0]   req_level,
   input  logic [NREQ*32-1:0]        req_data,
   output logic [NREQ-1:0]           req_rd,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      err
`ifdef BTPIPE_OUT_SCHED_STATS_EN
   ,
   output logic [NREQ*16-1:0]        blk_count
`endif
);

   localparam int unsigned CNT_W = $clog2(BLOCK_WORDS) + 1;

   sched_state_t     state, state_nxt;
   logic [CNT_W-1:0] word_cnt;
   logic [2:0]       rr_ptr;
   logic [NREQ-1:0]  eligible;
   logic [2:0]       pick_idx;
   logic             pick_valid;
   logic             blk_done;

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         eligible[i] = (32'(req_level[i*LEVEL_W +: LEVEL_W]) >= BLOCK_WORDS);
      end
   end

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .idx      (pick_idx),
      .valid    (pick_valid)
   );

   assign blk_done = (state == ST_XFER) && ep_read
                     && (word_cnt == CNT_W'(BLOCK_WORDS - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pick_valid)     state_nxt = ST_GRANT;
         ST_GRANT: if (ep_blockstrobe) state_nxt = ST_XFER;
         ST_XFER:  if (blk_done)       state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_rd    = '0;
      ep_datain = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if ((state == ST_XFER) && (grant_id == 3'(i))) begin
            req_rd[i] = ep_read;
            ep_datain = req_data[i*32 +: 32];
         end
      end
   end

   assign busy = (state == ST_GRANT) || (state == ST_XFER);

   always_ff @(posedge okClk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ep_ready <= 1'b0;
         grant_id <= '0;
         word_cnt <= '0;
         rr_ptr   <= 3'(NREQ - 1);
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         // Ready follows GRANT by one edge, so a grant needs two cycles.
         ep_ready <= (state == ST_GRANT) && !ep_blockstrobe;
         if ((state == ST_IDLE) && pick_valid) begin
            grant_id <= pick_idx;
         end
         if ((state == ST_GRANT) && ep_blockstrobe) begin
            word_cnt <= '0;
         end else if ((state == ST_XFER) && ep_read && !blk_done) begin
            word_cnt <= word_cnt + 1'b1;
         end else if (blk_done) begin
            word_cnt <= '0;
         end
         if (blk_done) begin
            rr_ptr <= grant_id;
         end
         if ((ep_read && (state != ST_XFER))
             || (ep_blockstrobe && (state != ST_GRANT))) begin
            err <= 1'b1;
         end
      end
   end

`ifdef BTPIPE_OUT_SCHED_STATS_EN
   logic [15:0] blk_cnt_q [NREQ];

   always_ff @(posedge okClk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            blk_cnt_q[i] <= '0;
         end
      end else if (blk_done) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if ((grant_id == 3'(i)) && (blk_cnt_q[i] != '1)) begin
               blk_cnt_q[i] <= blk_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      blk_count = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         blk_count[i*16 +: 16] = blk_cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_btpipe_out_sched.sv
module tb_btpipe_out_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned BW   = 256;

   logic          okClk = 1'b0;
   logic          rst;
   logic          ep_read;
   logic          ep_blockstrobe;
   logic [31:0]   ep_datain;
   logic          ep_ready;
   logic [63:0]   req_level;
   logic [127:0]  req_data;
   logic [3:0]    req_rd;
   logic [2:0]    grant_id;
   logic          busy;
   logic          err;
`ifdef BTPIPE_OUT_SCHED_STATS_EN
   logic [63:0]   blk_count;
`endif

   int unsigned npass  = 0;
   int unsigned ntotal = 0;

   always #5 okClk = ~okClk;

   btpipe_out_sched #(
      .NREQ        (NREQ),
      .BLOCK_WORDS (BW),
      .LEVEL_W     (16)
   ) dut (
      .okClk          (okClk),
      .rst            (rst),
      .ep_read        (ep_read),
      .ep_blockstrobe (ep_blockstrobe),
      .ep_datain      (ep_datain),
      .ep_ready       (ep_ready),
      .req_level      (req_level),
      .req_data       (req_data),
      .req_rd         (req_rd),
      .grant_id       (grant_id),
      .busy           (busy),
      .err            (err)
`ifdef BTPIPE_OUT_SCHED_STATS_EN
      ,
      .blk_count      (blk_count)
`endif
   );

   typedef struct {
      logic [3:0]  mask;
      int unsigned gid;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge okClk);
      #1;
   endtask

   function automatic logic [31:0] exp_data(input int unsigned g);
      return 32'hC0DE_0000 + g * 32'h1111;
   endfunction

   task automatic set_levels(input logic [3:0] mask, input int unsigned val);
      for (int i = 0; i < 4; i++) req_level[i*16 +: 16] = mask[i] ? 16'(val) : 16'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ep_read = 1'b0;
      ep_blockstrobe = 1'b0;
      req_level = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Expects to be called in IDLE with levels just applied.
   task automatic run_block(input int unsigned gid, input string tag);
      int unsigned n = 0;
      int unsigned pops = 0;
      logic [3:0] onehot;
      onehot = 4'(1 << gid);
      while (!ep_ready && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_ready_lat"}, n, 2);
      chk({tag, "_grant"}, 32'(grant_id), gid);
      chk({tag, "_busy_grant"}, 32'(busy), 1);
      ep_blockstrobe = 1'b1;
      tick();
      ep_blockstrobe = 1'b0;
      chk({tag, "_ready_clr"}, 32'(ep_ready), 0);
      for (int w = 0; w < int'(BW); w++) begin
         ep_read = 1'b1;
         #1;
         if (req_rd == onehot) pops++;
         if (w == 0 || w == int'(BW) - 1) chk({tag, "_data"}, ep_datain, exp_data(gid));
         tick();
      end
      ep_read = 1'b0;
      #1;
      chk({tag, "_pops"}, pops, BW);
      chk({tag, "_idle"}, 32'(busy), 0);
      chk({tag, "_data_idle"}, ep_datain, 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = exp_data(i);
      tbl[0] = '{4'b1111, 0};
      tbl[1] = '{4'b1111, 1};
      tbl[2] = '{4'b1111, 2};
      tbl[3] = '{4'b1111, 3};
      tbl[4] = '{4'b1111, 0};
      tbl[5] = '{4'b0100, 2};
      tbl[6] = '{4'b0011, 0};
      tbl[7] = '{4'b1010, 1};
      tbl[8] = '{4'b1001, 3};
      tbl[9] = '{4'b1000, 3};

      do_reset();
      chk("rst_ready", 32'(ep_ready), 0);
      chk("rst_rd", 32'(req_rd), 0);
      chk("rst_data", ep_datain, 0);
      chk("rst_gid", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);

      // Single requester 2
      set_levels(4'b0100, 256);
      run_block(2, "solo2");

      // Round-robin table
      do_reset();
      for (int v = 0; v < 10; v++) begin
         set_levels(tbl[v].mask, 256);
         run_block(tbl[v].gid, $sformatf("rr%0d", v));
      end

      // Level threshold
      do_reset();
      set_levels(4'b0010, 255);
      for (int i = 0; i < 5; i++) tick();
      chk("lvl255_ready", 32'(ep_ready), 0);
      chk("lvl255_busy", 32'(busy), 0);
      set_levels(4'b0010, 256);
      tick();
      chk("lvl256_ready1", 32'(ep_ready), 0);
      tick();
      chk("lvl256_ready2", 32'(ep_ready), 1);
      chk("lvl256_gid", 32'(grant_id), 1);

      // Read and strobe together in GRANT
      ep_blockstrobe = 1'b1;
      ep_read = 1'b1;
      #1;
      chk("both_no_pop", 32'(req_rd), 0);
      tick();
      ep_blockstrobe = 1'b0;
      ep_read = 1'b0;
      chk("both_xfer", 32'(busy), 1);
      chk("both_err", 32'(err), 1);

      // Read in IDLE
      do_reset();
      ep_read = 1'b1;
      #1;
      chk("idle_rd_no_pop", 32'(req_rd), 0);
      tick();
      ep_read = 1'b0;
      chk("idle_rd_err", 32'(err), 1);
      for (int i = 0; i < 4; i++) tick();
      chk("idle_rd_err_sticky", 32'(err), 1);
      do_reset();
      chk("err_cleared", 32'(err), 0);

      // Strobe in IDLE
      ep_blockstrobe = 1'b1;
      tick();
      ep_blockstrobe = 1'b0;
      chk("idle_strobe_err", 32'(err), 1);
      chk("idle_strobe_busy", 32'(busy), 0);

      // Reset mid-block
      do_reset();
      set_levels(4'b0001, 256);
      tick();
      tick();
      ep_blockstrobe = 1'b1;
      tick();
      ep_blockstrobe = 1'b0;
      for (int w = 0; w < 100; w++) begin
         ep_read = 1'b1;
         tick();
      end
      rst = 1'b1;
      #1;
      chk("abort_ready", 32'(ep_ready), 0);
      chk("abort_rd", 32'(req_rd), 0);
      chk("abort_data", ep_datain, 0);
      chk("abort_gid", 32'(grant_id), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_err", 32'(err), 0);
      ep_read = 1'b0;
      req_level = '0;
      tick();
      rst = 1'b0;
      tick();
      set_levels(4'b1111, 256);
      run_block(0, "after_abort");

`ifdef BTPIPE_OUT_SCHED_STATS_EN
      do_reset();
      for (int b = 0; b < 3; b++) begin
         set_levels(4'b1000, 256);
         run_block(3, $sformatf("stat%0d", b));
      end
      chk("blk_count3", 32'(blk_count[48 +: 16]), 3);
      chk("blk_count0", 32'(blk_count[0 +: 16]), 0);
      chk("blk_count1", 32'(blk_count[16 +: 16]), 0);
      chk("blk_count2", 32'(blk_count[32 +: 16]), 0);
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
